controle_posicoes: RTL and testbench
====================================

// Module: controle_posicoes
// PURPOSE
//   Sequential game-position controller for the two-player 16-square board.
//   Samples the four player buttons and applies the repeating step sequence 1,2,3,3,2,1,0.
//   Moves each player with saturation and collision rejection.
//   Drives memoria1/memoria2, which the downstream LED decoder consumes directly.
// PARAMETERS
//   POS_INICIAL_J1   0    reset square of player 1 (4-bit value)
//   POS_INICIAL_J2   15   reset square of player 2 (4-bit value)
//   DEBOUNCE_CICLOS  4    stable cycles required per button (used only with DEBOUNCE_EN)
// PORTS
//   clk        in   1  single system clock; all state changes on posedge
//   rst_n      in   1  reset, synchronous, active-low
//   botao1     in   1  player 2 advance (toward square 0); async raw level
//   botao2     in   1  player 2 retreat (toward square 15); async raw level
//   botao3     in   1  player 1 advance (toward square 15); async raw level
//   botao4     in   1  player 1 retreat (toward square 0); async raw level
//   memoria1   out  4  player 1 square
//   memoria2   out  4  player 2 square
//   turno      out  3  current step size, 0..3
//   vez        out  1  0 = player 1 to move, 1 = player 2 to move
//   mov_ok     out  1  1-cycle pulse: move committed
//   colisao    out  1  1-cycle pulse: move rejected because destination = opponent square
//   fim_jogo   out  1  sticky: player 1 reached 15 or player 2 reached 0
// BEHAVIOUR
//   Reset (rst_n=0 at posedge) sets:
//     memoria1=POS_INICIAL_J1, memoria2=POS_INICIAL_J2, seq index=0 (turno=1), vez=0.
//     mov_ok=0, colisao=0, fim_jogo=0, FSM=ESPERA.
//   Reset mid-operation aborts any pending move; no partial update.
//   Buttons: 2-flop synchronizer, then rising-edge detect.
//     A press is one edge; holding a button gives exactly one press.
//   FSM:
//     ESPERA: wait for a valid press.
//       Only the buttons of the player named by vez are considered.
//       Both buttons of that player edging in the same cycle -> ignored, stay in ESPERA.
//       Exactly one edge -> latch direction, go to CALCULA.
//     CALCULA: 5-bit destination = own square +/- turno.
//       Result >15 clamps to 15; result <0 clamps to 0.
//       Compare destination with the opponent square. Go to APLICA.
//     APLICA:
//       If the destination equals the opponent square: no move, colisao=1.
//         vez and the sequence do not change; the same player moves again.
//       Otherwise: write own square, mov_ok=1, toggle vez, advance seq index.
//         Seq index runs 0..6 and wraps 6->0.
//       If player 1 is now at 15 or player 2 is now at 0: go to FIM. Else go to ESPERA.
//     FIM: every button is ignored; outputs hold until reset.
//   Latency: sync edge in cycle N -> CALCULA N+1 -> memoria/pulse update visible at N+2 (registered).
//     Presses that arrive while in CALCULA or APLICA are dropped.
//   turno=0 (7th step): the press is accepted as a pass.
//     Square is unchanged, mov_ok=1, vez toggles, seq advances. No collision is possible.
//   Saturated move with no change (e.g. player 1 at 15 retreat... player 1 at 0, botao4):
//     still a committed pass, mov_ok=1.
//   All outputs are registered; no combinational path from input to output.
// CONFIGURATION
//   DEBOUNCE_EN defined:
//     Each synchronized button feeds a counter.
//     The debounced level changes only after DEBOUNCE_CICLOS consecutive equal samples.
//     Edge detect runs on the debounced level. Latency grows by DEBOUNCE_CICLOS cycles.
//   DEBOUNCE_EN undefined: synchronizer and edge detect only; DEBOUNCE_CICLOS is unused.
// TESTING
//   1. Reset, botao3 pulse -> after 2 cycles memoria1=1, mov_ok pulse, vez=1, turno=2.
//   2. Full sequence of alternating advances (b3,b1,...), 7 moves -> turno reads 1,2,3,3,2,1,0, then wraps to 1.
//   3. memoria1=12, memoria2=15, turno=3, b3 -> colisao pulse; memoria1 stays 12; vez stays 0; turno stays 3.
//   4. memoria1=0, vez=0, turno=2, b4 -> memoria1 stays 0 (clamped), mov_ok=1, vez=1.
//   5. b3 and b4 edge in the same cycle with vez=0 -> no state change. b1 while vez=0 -> ignored.
//   6. Player 1 reaches 15 -> fim_jogo=1 and all buttons ignored.
//      rst_n=0 for one cycle -> all reset values restored.

Source files
------------

// File: rtl/controle_posicoes.sv
// Two-player 16-square position controller: button sync/edge detect, step sequence 1,2,3,3,2,1,0,
// saturating moves with collision rejection. Optional debounce filter enabled by defining DEBOUNCE_EN.
module controle_posicoes #(
  parameter logic [3:0] POS_INICIAL_J1  = 4'd0,
  parameter logic [3:0] POS_INICIAL_J2  = 4'd15,
  parameter int         DEBOUNCE_CICLOS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       botao1,
  input  logic       botao2,
  input  logic       botao3,
  input  logic       botao4,
  output logic [3:0] memoria1,
  output logic [3:0] memoria2,
  output logic [2:0] turno,
  output logic       vez,
  output logic       mov_ok,
  output logic       colisao,
  output logic       fim_jogo
);

  typedef enum logic [1:0] {ESPERA, CALCULA, APLICA, FIM} estado_t;

  if (DEBOUNCE_CICLOS < 1) begin : g_param_invalido
    $error("DEBOUNCE_CICLOS must be at least 1");
  end

  logic [3:0] botoes;
  logic [3:0] sinc1_reg, sinc2_reg;
  logic [3:0] nivel;
  logic [3:0] nivel_ant_reg;
  logic [3:0] borda;

  assign botoes = {botao4, botao3, botao2, botao1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sinc1_reg     <= 4'd0;
      sinc2_reg     <= 4'd0;
      nivel_ant_reg <= 4'd0;
    end else begin
      sinc1_reg     <= botoes;
      sinc2_reg     <= sinc1_reg;
      nivel_ant_reg <= nivel;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      logic [CW-1:0] cnt_reg;
      logic          nivel_reg;

      // Level flips only on the DEBOUNCE_CICLOS-th consecutive sample that disagrees with it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg   <= '0;
          nivel_reg <= 1'b0;
        end else if (sinc2_reg[gi] == nivel_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CW'(DEBOUNCE_CICLOS - 1)) begin
          cnt_reg   <= '0;
          nivel_reg <= sinc2_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign nivel[gi] = nivel_reg;
    end
  endgenerate
`else
  assign nivel = sinc2_reg;
`endif

  assign borda = nivel & ~nivel_ant_reg;

  estado_t    estado_reg, estado_next;
  logic [3:0] m1_reg, m1_next;
  logic [3:0] m2_reg, m2_next;
  logic [2:0] seq_reg, seq_next;
  logic [2:0] turno_reg, turno_next;
  logic       vez_reg, vez_next;
  logic       dir_reg, dir_next;
  logic       mov_ok_reg, mov_ok_next;
  logic       colisao_reg, colisao_next;
  logic       fim_reg, fim_next;

  logic [3:0] propria, oponente, destino;
  logic [4:0] soma, diferenca;
  logic [2:0] seq_inc;
  logic       colide;

  function automatic logic [2:0] passo(input logic [2:0] idx);
    case (idx)
      3'd0:    passo = 3'd1;
      3'd1:    passo = 3'd2;
      3'd2:    passo = 3'd3;
      3'd3:    passo = 3'd3;
      3'd4:    passo = 3'd2;
      3'd5:    passo = 3'd1;
      default: passo = 3'd0;
    endcase
  endfunction

  // Destination is computed 5 bits wide so both overflow past 15 and borrow below 0 are visible.
  assign propria   = vez_reg ? m2_reg : m1_reg;
  assign oponente  = vez_reg ? m1_reg : m2_reg;
  assign soma      = {1'b0, propria} + {2'b00, turno_reg};
  assign diferenca = {1'b0, propria} - {2'b00, turno_reg};
  assign destino   = dir_reg ? (soma[4] ? 4'd15 : soma[3:0])
                             : (diferenca[4] ? 4'd0 : diferenca[3:0]);
  assign colide    = (turno_reg != 3'd0) && (destino == oponente);
  assign seq_inc   = (seq_reg == 3'd6) ? 3'd0 : seq_reg + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_reg  <= ESPERA;
      m1_reg      <= POS_INICIAL_J1;
      m2_reg      <= POS_INICIAL_J2;
      seq_reg     <= 3'd0;
      turno_reg   <= 3'd1;
      vez_reg     <= 1'b0;
      dir_reg     <= 1'b0;
      mov_ok_reg  <= 1'b0;
      colisao_reg <= 1'b0;
      fim_reg     <= 1'b0;
    end else begin
      estado_reg  <= estado_next;
      m1_reg      <= m1_next;
      m2_reg      <= m2_next;
      seq_reg     <= seq_next;
      turno_reg   <= turno_next;
      vez_reg     <= vez_next;
      dir_reg     <= dir_next;
      mov_ok_reg  <= mov_ok_next;
      colisao_reg <= colisao_next;
      fim_reg     <= fim_next;
    end
  end

  always_comb begin
    estado_next  = estado_reg;
    m1_next      = m1_reg;
    m2_next      = m2_reg;
    seq_next     = seq_reg;
    turno_next   = turno_reg;
    vez_next     = vez_reg;
    dir_next     = dir_reg;
    mov_ok_next  = 1'b0;
    colisao_next = 1'b0;
    fim_next     = fim_reg;

    case (estado_reg)
      ESPERA: begin
        if (!vez_reg) begin
          if (borda[2] ^ borda[3]) begin
            dir_next    = borda[2];
            estado_next = CALCULA;
          end
        end else if (borda[0] ^ borda[1]) begin
          dir_next    = borda[1];
          estado_next = CALCULA;
        end
      end
      // Commit happens on the CALCULA->APLICA edge so results and pulses are visible during APLICA.
      CALCULA: begin
        estado_next = APLICA;
        if (colide) begin
          colisao_next = 1'b1;
        end else begin
          if (vez_reg) m2_next = destino;
          else         m1_next = destino;
          mov_ok_next = 1'b1;
          vez_next    = ~vez_reg;
          seq_next    = seq_inc;
          turno_next  = passo(seq_inc);
        end
      end
      APLICA: begin
        if ((m1_reg == 4'd15) || (m2_reg == 4'd0)) begin
          estado_next = FIM;
          fim_next    = 1'b1;
        end else begin
          estado_next = ESPERA;
        end
      end
      default: estado_next = FIM;
    endcase
  end

  assign memoria1 = m1_reg;
  assign memoria2 = m2_reg;
  assign turno    = turno_reg;
  assign vez      = vez_reg;
  assign mov_ok   = mov_ok_reg;
  assign colisao  = colisao_reg;
  assign fim_jogo = fim_reg;

endmodule

// File: tb/tb_controle_posicoes.sv
// Scoreboard bench for controle_posicoes: a reference game model queues the expected outcome
// of each press, and the observed mov_ok/colisao pulse pops and checks it.
module tb_controle_posicoes;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       botao1, botao2, botao3, botao4;
  logic [3:0] memoria1, memoria2;
  logic [2:0] turno;
  logic       vez, mov_ok, colisao, fim_jogo;

  controle_posicoes dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .botao1   (botao1),
    .botao2   (botao2),
    .botao3   (botao3),
    .botao4   (botao4),
    .memoria1 (memoria1),
    .memoria2 (memoria2),
    .turno    (turno),
    .vez      (vez),
    .mov_ok   (mov_ok),
    .colisao  (colisao),
    .fim_jogo (fim_jogo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       colide;
    logic [3:0] m1;
    logic [3:0] m2;
    logic       vez;
    logic [2:0] turno;
  } esperado_t;

  esperado_t fila[$];
  int erros  = 0;
  int checks = 0;

  logic [3:0] mod_m1, mod_m2;
  logic [2:0] mod_idx;
  logic       mod_vez, mod_fim;
  logic       ultima_colisao;

  function automatic logic [2:0] passo_ref(input logic [2:0] idx);
    logic [2:0] tabela [7];
    tabela = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    return tabela[idx];
  endfunction

  // mask bit0..bit3 = botao1..botao4
  task automatic press(input logic [3:0] mask, input string nome);
    logic      valido, sobe;
    int        propria, oponente, t, dest, eventos;
    esperado_t e;
    valido = 1'b0;
    sobe   = 1'b0;
    ultima_colisao = 1'b0;
    if (!mod_fim) begin
      if (!mod_vez && (mask[2] ^ mask[3])) begin
        valido = 1'b1; sobe = mask[2];
      end else if (mod_vez && (mask[0] ^ mask[1])) begin
        valido = 1'b1; sobe = mask[1];
      end
    end
    if (valido) begin
      propria  = mod_vez ? int'(mod_m2) : int'(mod_m1);
      oponente = mod_vez ? int'(mod_m1) : int'(mod_m2);
      t        = int'(passo_ref(mod_idx));
      dest     = sobe ? propria + t : propria - t;
      if (dest > 15) dest = 15;
      if (dest < 0)  dest = 0;
      if (t != 0 && dest == oponente) begin
        e.colide = 1'b1;
        ultima_colisao = 1'b1;
      end else begin
        e.colide = 1'b0;
        if (mod_vez) mod_m2 = 4'(dest);
        else         mod_m1 = 4'(dest);
        mod_vez = ~mod_vez;
        mod_idx = (mod_idx == 3'd6) ? 3'd0 : mod_idx + 3'd1;
        if (mod_m1 == 4'd15 || mod_m2 == 4'd0) mod_fim = 1'b1;
      end
      e.m1 = mod_m1; e.m2 = mod_m2; e.vez = mod_vez; e.turno = passo_ref(mod_idx);
      fila.push_back(e);
    end

    @(negedge clk);
    {botao4, botao3, botao2, botao1} = mask;
    eventos = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 8) {botao4, botao3, botao2, botao1} = 4'b0000;
      if (mov_ok === 1'b1 || colisao === 1'b1) begin
        eventos++;
        checks++;
        if (fila.size() == 0) begin
          erros++;
          $display("FAIL %s unexpected_event mov_ok=%b colisao=%b required none", nome, mov_ok, colisao);
        end else begin
          e = fila.pop_front();
          if ({colisao, mov_ok, memoria1, memoria2, vez, turno} !==
              {e.colide, ~e.colide, e.m1, e.m2, e.vez, e.turno}) begin
            erros++;
            $display("FAIL %s outcome got col=%b ok=%b m1=%0d m2=%0d vez=%b turno=%0d required col=%b ok=%b m1=%0d m2=%0d vez=%b turno=%0d",
                     nome, colisao, mov_ok, memoria1, memoria2, vez, turno,
                     e.colide, ~e.colide, e.m1, e.m2, e.vez, e.turno);
          end
        end
      end
    end
    checks++;
    if (eventos != (valido ? 1 : 0)) begin
      erros++;
      $display("FAIL %s event_count got %0d required %0d", nome, eventos, valido ? 1 : 0);
    end
    fila.delete();
    checks++;
    if ({memoria1, memoria2, vez, turno, fim_jogo} !==
        {mod_m1, mod_m2, mod_vez, passo_ref(mod_idx), mod_fim}) begin
      erros++;
      $display("FAIL %s settled_state got m1=%0d m2=%0d vez=%b turno=%0d fim=%b required m1=%0d m2=%0d vez=%b turno=%0d fim=%b",
               nome, memoria1, memoria2, vez, turno, fim_jogo,
               mod_m1, mod_m2, mod_vez, passo_ref(mod_idx), mod_fim);
    end
    $display("press %-10s mask=%b valid=%b col=%b -> m1=%0d m2=%0d vez=%b turno=%0d fim=%b",
             nome, mask, valido, ultima_colisao, memoria1, memoria2, vez, turno, fim_jogo);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {botao4, botao3, botao2, botao1} = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mod_m1 = 4'd0; mod_m2 = 4'd15; mod_idx = 3'd0; mod_vez = 1'b0; mod_fim = 1'b0;
    fila.delete();
    @(negedge clk);
    checks++;
    if (memoria1 !== 4'd0) begin erros++; $display("FAIL reset_memoria1 got %0d required 0", memoria1); end
    checks++;
    if (memoria2 !== 4'd15) begin erros++; $display("FAIL reset_memoria2 got %0d required 15", memoria2); end
    checks++;
    if (turno !== 3'd1) begin erros++; $display("FAIL reset_turno got %0d required 1", turno); end
    checks++;
    if ({vez, mov_ok, colisao, fim_jogo} !== 4'b0000) begin
      erros++; $display("FAIL reset_flags got vez/ok/col/fim=%b required 0000", {vez, mov_ok, colisao, fim_jogo});
    end
    $display("reset applied: m1=%0d m2=%0d turno=%0d vez=%b", memoria1, memoria2, turno, vez);
  endtask

  task automatic test_first_move();
    press(4'b0100, "b3_first");
  endtask

  task automatic test_sequence();
    for (int i = 0; i < 6; i++) press(mod_vez ? 4'b0001 : 4'b0100, mod_vez ? "b1_seq" : "b3_seq");
    checks++;
    if (turno !== 3'd1) begin erros++; $display("FAIL seq_wrap turno got %0d required 1", turno); end
  endtask

  task automatic test_ignored();
    press(4'b0001, "b1_p2");
    press(4'b0001, "b1_offturn");
    press(4'b1100, "b3b4_both");
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 8; i++) press(mod_vez ? 4'b0010 : 4'b1000, mod_vez ? "b2_ret" : "b4_ret");
  endtask

  task automatic test_collision();
    int colisoes = 0;
    for (int i = 0; i < 40 && colisoes < 2; i++) begin
      press(mod_vez ? 4'b0010 : 4'b0100, mod_vez ? "b2_hold15" : "b3_adv");
      if (ultima_colisao) colisoes++;
    end
    checks++;
    if (colisoes != 2) begin erros++; $display("FAIL collision_reached got %0d collisions required 2", colisoes); end
  endtask

  task automatic test_fim();
    for (int i = 0; i < 60 && !mod_fim; i++) begin
      if (!mod_vez) press(ultima_colisao ? 4'b1000 : 4'b0100, ultima_colisao ? "b4_evade" : "b3_adv");
      else          press(ultima_colisao ? 4'b0010 : 4'b0001, ultima_colisao ? "b2_evade" : "b1_adv");
    end
    checks++;
    if (fim_jogo !== 1'b1) begin erros++; $display("FAIL fim_reached got %b required 1", fim_jogo); end
    press(4'b1111, "all_after_fim");
    press(4'b0100, "b3_after_fim");
    press(4'b0001, "b1_after_fim");
  endtask

  initial begin
    rst_n = 1'b0;
    {botao4, botao3, botao2, botao1} = 4'b0000;
    ultima_colisao = 1'b0;
    test_reset();
    test_first_move();
    test_sequence();
    test_ignored();
    test_clamp();
    test_collision();
    test_fim();
    test_reset();
    press(4'b0100, "b3_after_rst");
    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
